intra_sad_calc: RTL and testbench

INTRA_SAD_CALC -- requirements
Module: intra_sad_calc

---
 rtl/intra_sad_calc.sv | 128 ++++++++++++
 tb/tb_intra_sad_calc.sv | 228 ++++++++++++++++++++++
 2 files changed

// File: rtl/intra_sad_calc.sv
// Intra-prediction SAD and residue engine: accumulates per-mode |orig-pred| over one macroblock.
// Optional macro INTRA_SIGNED_RESIDUE_EN stores clamped signed residues instead of absolute ones.
module intra_sad_calc #(
   parameter int unsigned MB_SIZE_L = 8,
   parameter int unsigned MB_SIZE_W = 8,
   localparam int unsigned NUM_MODES = (MB_SIZE_L == 4) ? 8 : 3,
   localparam int unsigned NPIX = MB_SIZE_L * MB_SIZE_W
) (
   input  logic                                  clk,
   input  logic                                  reset,
   input  logic                                  start,
   input  logic [12:0]                           mbnumber_in,
   input  logic                                  pix_valid,
   input  logic [7:0]                            orig_pix,
   input  logic [NUM_MODES-1:0][7:0]             pred_pix,
   output logic                                  busy,
   output logic                                  done,
   output logic [NUM_MODES-1:0][7:0]             sads,
   output logic [NUM_MODES-1:0][NPIX-1:0][7:0]   allresidues,
   output logic [12:0]                           mbnumber
);

   localparam int unsigned CNT_W = $clog2(NPIX);
   localparam int unsigned ACC_W = 16;
   localparam logic [CNT_W-1:0] LAST_PIX = CNT_W'(NPIX - 1);
   localparam logic [ACC_W-1:0] SAT_MAX  = ACC_W'(255);

   typedef enum logic [1:0] {IDLE, ACCUM, DONE} state_t;

   state_t                            state, state_nx;
   logic                              clear_c, accept_c, last_c;
   logic [CNT_W-1:0]                  pix_cnt;
   logic [12:0]                       mb_capt;
   logic [NUM_MODES-1:0][ACC_W-1:0]   acc, acc_nx;
   logic [NUM_MODES-1:0][8:0]         diff;
   logic [NUM_MODES-1:0][7:0]         absd, resid;

   // State register
   always_ff @(posedge clk) begin
      if (!reset) state <= IDLE;
      else        state <= state_nx;
   end

   // Next state and datapath strobes
   always_comb begin
      state_nx = state;
      clear_c  = 1'b0;
      accept_c = 1'b0;
      last_c   = 1'b0;
      case (state)
         IDLE: begin
            if (start) begin
               clear_c  = 1'b1;
               state_nx = ACCUM;
            end
         end
         ACCUM: begin
            if (pix_valid) begin
               accept_c = 1'b1;
               if (pix_cnt == LAST_PIX) begin
                  last_c   = 1'b1;
                  state_nx = DONE;
               end
            end
         end
         DONE:    state_nx = IDLE;
         default: state_nx = IDLE;
      endcase
   end

   // Per-mode difference, absolute value, stored residue and next accumulator
   always_comb begin
      diff   = '0;
      absd   = '0;
      resid  = '0;
      acc_nx = '0;
      for (int m = 0; m < NUM_MODES; m++) begin
         diff[m] = {1'b0, orig_pix} - {1'b0, pred_pix[m]};
         absd[m] = diff[m][8] ? (~diff[m][7:0] + 8'd1) : diff[m][7:0];
`ifdef INTRA_SIGNED_RESIDUE_EN
         // bits 8 and 7 disagree only when the 9-bit value leaves [-128,127]
         if (diff[m][8] && !diff[m][7])      resid[m] = 8'h80;
         else if (!diff[m][8] && diff[m][7]) resid[m] = 8'h7F;
         else                                resid[m] = diff[m][7:0];
`else
         resid[m] = absd[m];
`endif
         acc_nx[m] = acc[m] + ACC_W'(absd[m]);
      end
   end

   // Accumulators, residue store and registered outputs
   always_ff @(posedge clk) begin
      if (!reset) begin
         pix_cnt     <= '0;
         mb_capt     <= '0;
         acc         <= '0;
         busy        <= 1'b0;
         done        <= 1'b0;
         sads        <= '0;
         mbnumber    <= '0;
         allresidues <= '0;
      end else begin
         busy <= (state_nx != IDLE);
         done <= (state_nx == DONE);
         if (clear_c) begin
            pix_cnt <= '0;
            acc     <= '0;
            mb_capt <= mbnumber_in;
         end
         if (accept_c) begin
            acc     <= acc_nx;
            pix_cnt <= last_c ? '0 : pix_cnt + CNT_W'(1);
            for (int m = 0; m < NUM_MODES; m++) begin
               allresidues[m][pix_cnt] <= resid[m];
            end
         end
         // Results include the final pixel, so saturate the next-cycle sums
         if (last_c) begin
            mbnumber <= mb_capt;
            for (int m = 0; m < NUM_MODES; m++) begin
               sads[m] <= (acc_nx[m] > SAT_MAX) ? 8'hFF : acc_nx[m][7:0];
            end
         end
      end
   end

endmodule

// File: tb/tb_intra_sad_calc.sv
// Directed bench for intra_sad_calc: 8x8 table of constant blocks plus reset-abort and 4x4 eight-mode cases.
module tb_intra_sad_calc;

   localparam int unsigned NM  = 3;
   localparam int unsigned NP  = 64;
   localparam int unsigned NM4 = 8;
   localparam int unsigned NP4 = 16;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic reset;

   logic                      start, pix_valid, busy, done;
   logic [12:0]               mbnumber_in, mbnumber;
   logic [7:0]                orig_pix;
   logic [NM-1:0][7:0]        pred_pix, sads;
   logic [NM-1:0][NP-1:0][7:0] allresidues;

   logic                        start4, pix_valid4, busy4, done4;
   logic [12:0]                 mbnumber_in4, mbnumber4;
   logic [7:0]                  orig_pix4;
   logic [NM4-1:0][7:0]         pred_pix4, sads4;
   logic [NM4-1:0][NP4-1:0][7:0] allresidues4;

   intra_sad_calc dut (
      .clk(clk), .reset(reset), .start(start), .mbnumber_in(mbnumber_in),
      .pix_valid(pix_valid), .orig_pix(orig_pix), .pred_pix(pred_pix),
      .busy(busy), .done(done), .sads(sads), .allresidues(allresidues),
      .mbnumber(mbnumber)
   );

   intra_sad_calc #(.MB_SIZE_L(4), .MB_SIZE_W(4)) dut4 (
      .clk(clk), .reset(reset), .start(start4), .mbnumber_in(mbnumber_in4),
      .pix_valid(pix_valid4), .orig_pix(orig_pix4), .pred_pix(pred_pix4),
      .busy(busy4), .done(done4), .sads(sads4), .allresidues(allresidues4),
      .mbnumber(mbnumber4)
   );

   typedef struct packed {
      logic [7:0]      orig;
      logic [2:0][7:0] pred;
      logic [12:0]     mb;
      logic            gap;
      logic            noise;
      logic [2:0][7:0] sad;
      logic [2:0][7:0] res_u;
      logic [2:0][7:0] res_s;
   } vec_t;

   vec_t vecs [5];
   int   tests = 0;
   int   fails = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   function automatic vec_t mk(input logic [7:0] o, input logic [7:0] p0, p1, p2,
                               input logic [12:0] mb, input logic gap, noise,
                               input logic [7:0] s0, s1, s2, u0, u1, u2, q0, q1, q2);
      vec_t v;
      v.orig = o;  v.mb = mb;  v.gap = gap;  v.noise = noise;
      v.pred[0] = p0;  v.pred[1] = p1;  v.pred[2] = p2;
      v.sad[0]  = s0;  v.sad[1]  = s1;  v.sad[2]  = s2;
      v.res_u[0] = u0; v.res_u[1] = u1; v.res_u[2] = u2;
      v.res_s[0] = q0; v.res_s[1] = q1; v.res_s[2] = q2;
      return v;
   endfunction

   function automatic logic [7:0] exp_res(input vec_t v, input int m);
`ifdef INTRA_SIGNED_RESIDUE_EN
      return v.res_s[m];
`else
      return v.res_u[m];
`endif
   endfunction

   task automatic run_block(input vec_t v, input int idx);
      int early = 0;
      int bad;
      logic [7:0] first_bad;
      @(negedge clk);
      start = 1'b1;  mbnumber_in = v.mb;
      @(negedge clk);
      start = v.noise;  mbnumber_in = v.noise ? 13'd99 : v.mb;
      chk($sformatf("v%0d busy_accum", idx), 32'(busy), 32'd1);
      for (int k = 0; k < NP; k++) begin
         if (v.gap) begin
            pix_valid = 1'b0;
            @(negedge clk);
            if (done) early++;
         end
         pix_valid = 1'b1;
         orig_pix  = v.orig;
         for (int m = 0; m < NM; m++) pred_pix[m] = v.pred[m];
         @(negedge clk);
         if (k < NP - 1 && done) early++;
      end
      pix_valid = 1'b0;
      chk($sformatf("v%0d early_done", idx), 32'(early), 32'd0);
      chk($sformatf("v%0d done", idx), 32'(done), 32'd1);
      chk($sformatf("v%0d busy_done", idx), 32'(busy), 32'd1);
      chk($sformatf("v%0d mbnumber", idx), 32'(mbnumber), 32'(v.mb));
      for (int m = 0; m < NM; m++) begin
         chk($sformatf("v%0d sad%0d", idx, m), 32'(sads[m]), 32'(v.sad[m]));
         bad = 0;  first_bad = '0;
         for (int k = 0; k < NP; k++) begin
            if (allresidues[m][k] !== exp_res(v, m)) begin
               if (bad == 0) first_bad = allresidues[m][k];
               bad++;
            end
         end
         chk($sformatf("v%0d residue%0d", idx, m),
             (bad == 0) ? 32'(exp_res(v, m)) : 32'(first_bad), 32'(exp_res(v, m)));
      end
      @(negedge clk);
      start = 1'b0;
      chk($sformatf("v%0d done_pulse_end", idx), 32'(done), 32'd0);
      chk($sformatf("v%0d idle_after_done", idx), 32'(busy), 32'd0);
   endtask

   initial begin
      int seen;
      int bad;

      vecs[0] = mk(8'd100, 8'd100, 8'd101, 8'd90, 13'd5, 1'b0, 1'b0,
                   8'd0, 8'd64, 8'd255,  8'd0, 8'd1, 8'd10,  8'd0, 8'hFF, 8'd10);
      vecs[1] = mk(8'd0, 8'd255, 8'd0, 8'd3, 13'd1, 1'b0, 1'b0,
                   8'd255, 8'd0, 8'd192,  8'd255, 8'd0, 8'd3,  8'h80, 8'd0, 8'hFD);
      vecs[2] = mk(8'd100, 8'd100, 8'd101, 8'd90, 13'd6, 1'b1, 1'b0,
                   8'd0, 8'd64, 8'd255,  8'd0, 8'd1, 8'd10,  8'd0, 8'hFF, 8'd10);
      vecs[3] = mk(8'd200, 8'd199, 8'd204, 8'd0, 13'd8191, 1'b0, 1'b0,
                   8'd64, 8'd255, 8'd255,  8'd1, 8'd4, 8'd200,  8'd1, 8'hFC, 8'h7F);
      vecs[4] = mk(8'd50, 8'd52, 8'd50, 8'd47, 13'd37, 1'b0, 1'b1,
                   8'd128, 8'd0, 8'd192,  8'd2, 8'd0, 8'd3,  8'hFE, 8'd0, 8'd3);

      reset = 1'b0;
      start = 1'b0;  pix_valid = 1'b0;  mbnumber_in = '0;  orig_pix = '0;  pred_pix = '0;
      start4 = 1'b0; pix_valid4 = 1'b0; mbnumber_in4 = '0; orig_pix4 = '0; pred_pix4 = '0;
      repeat (2) @(negedge clk);
      chk("rst busy", 32'(busy), 32'd0);
      chk("rst done", 32'(done), 32'd0);
      chk("rst sads", 32'(sads), 32'd0);
      chk("rst mbnumber", 32'(mbnumber), 32'd0);
      chk("rst residues", 32'(allresidues != '0), 32'd0);
      reset = 1'b1;

      // pix_valid while idle must not start anything
      pix_valid = 1'b1;  orig_pix = 8'd9;
      repeat (3) @(negedge clk);
      chk("idle pix busy", 32'(busy), 32'd0);
      pix_valid = 1'b0;

      // Abort a block after 20 pixels with a reset that also sees start and pix_valid
      start = 1'b1;  mbnumber_in = 13'd11;
      @(negedge clk);
      start = 1'b0;
      for (int k = 0; k < 20; k++) begin
         pix_valid = 1'b1;  orig_pix = 8'd0;
         for (int m = 0; m < NM; m++) pred_pix[m] = 8'd200;
         @(negedge clk);
      end
      reset = 1'b0;  start = 1'b1;
      @(negedge clk);
      reset = 1'b1;  start = 1'b0;  pix_valid = 1'b0;
      chk("abort busy", 32'(busy), 32'd0);
      chk("abort sads", 32'(sads), 32'd0);
      chk("abort mbnumber", 32'(mbnumber), 32'd0);
      chk("abort residues", 32'(allresidues != '0), 32'd0);
      seen = 0;
      for (int k = 0; k < 70; k++) begin
         @(negedge clk);
         if (done) seen++;
      end
      chk("abort no done", 32'(seen), 32'd0);

      for (int i = 0; i < 5; i++) run_block(vecs[i], i);

      // Results hold while idle traffic arrives
      pix_valid = 1'b1;  orig_pix = 8'd250;
      repeat (5) @(negedge clk);
      pix_valid = 1'b0;
      chk("hold sad0", 32'(sads[0]), 32'd128);
      chk("hold mbnumber", 32'(mbnumber), 32'd37);
      chk("hold done", 32'(done), 32'd0);

      // 4x4 block, eight modes, pred = orig + m
      @(negedge clk);
      start4 = 1'b1;  mbnumber_in4 = 13'd4;
      @(negedge clk);
      start4 = 1'b0;
      seen = 0;
      for (int k = 0; k < NP4; k++) begin
         pix_valid4 = 1'b1;
         orig_pix4  = 8'(10 + 7 * k);
         for (int m = 0; m < NM4; m++) pred_pix4[m] = 8'(10 + 7 * k + m);
         @(negedge clk);
         if (k < NP4 - 1 && done4) seen++;
      end
      pix_valid4 = 1'b0;
      chk("m4 early_done", 32'(seen), 32'd0);
      chk("m4 done", 32'(done4), 32'd1);
      chk("m4 mbnumber", 32'(mbnumber4), 32'd4);
      for (int m = 0; m < NM4; m++) begin
         logic [7:0] er;
`ifdef INTRA_SIGNED_RESIDUE_EN
         er = 8'(256 - m);
`else
         er = 8'(m);
`endif
         chk($sformatf("m4 sad%0d", m), 32'(sads4[m]), 32'(16 * m));
         bad = 0;
         for (int k = 0; k < NP4; k++) if (allresidues4[m][k] !== er) bad++;
         chk($sformatf("m4 residue%0d bad_entries", m), 32'(bad), 32'd0);
      end
      @(negedge clk);
      chk("m4 done_end", 32'(done4), 32'd0);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
